fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream consumer of the byte-wide first-word-fall-through (FWFT) FIFO.
//  Pops one byte whenever the FIFO is non-empty and the line is idle, then serialises it as 8N1/8N2 UART, LSB first.
//  Sits between the FIFO's data_out/empty/en pins and the board TX pin.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit; legal range 2..65535 (868 = 100 MHz / 115200)
//  STOP_BITS     1    number of stop bits; legal values 1 or 2
// PORTS
//  clk         in   1  single clock; all logic on rising edge
//  rst         in   1  synchronous, active-high reset
//  fifo_data   in   8  FIFO head byte; valid whenever fifo_empty=0 (FWFT)
//  fifo_empty  in   1  FIFO empty flag
//  fifo_rd_en  out  1  pop strobe to the FIFO; 1-cycle pulse per byte
//  tx          out  1  serial line; idles high
//  busy        out  1  high from the pop cycle until the last stop bit ends
//  tx_done     out  1  1-cycle pulse in the cycle the last stop bit ends
// BEHAVIOUR
//  - Reset: state=IDLE, tx=1, busy=0, tx_done=0, baud counter=0, bit index=0.
//    fifo_rd_en is combinational and therefore 0 while in IDLE under reset.
//  - fifo_rd_en = (state==IDLE) && !fifo_empty && !rst. It is the only pop source and is never high outside IDLE.
//  - In the pop cycle, fifo_data is captured into an 8-bit shift register and the FSM moves to START on the same edge.
//    tx falls at the next edge; latency from the pop cycle to the start bit on tx is 1 clk.
//  - FSM states:
//    - IDLE:   tx=1 held. Leave for START when !fifo_empty.
//    - START:  tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//    - DATA:   tx=shreg[0]; shift right every CLKS_PER_BIT cycles; after 8 bits, go to PARITY (if the option is built) else STOP.
//    - PARITY: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
//    - STOP:   tx=1 for STOP_BITS*CLKS_PER_BIT cycles; at the end, pulse tx_done and go to IDLE.
//  - Baud counter: $clog2(CLKS_PER_BIT) bits wide. Counts 0..CLKS_PER_BIT-1, wraps to 0 and reloads to 0 on every state change.
//    The bit index is 3 bits and wraps 7->0 on exit from DATA.
//  - Back-to-back bytes: from STOP the FSM returns to IDLE for exactly 1 cycle.
//    If !fifo_empty in that cycle it pops and starts again, so there is 1 extra high clk between frames (no extra bit time).
//  - fifo_empty rising mid-frame has no effect; the captured byte completes.
//  - fifo_data changing mid-frame has no effect; only the shift register drives tx.
//  - rst asserted mid-frame: the next edge returns to IDLE with tx=1. The popped byte is dropped and not re-popped.
//    The receiver sees a truncated frame; this is accepted.
//  - busy = (state != IDLE). tx, busy and tx_done are all registered, so tx has no glitches.
// CONFIGURATION
//  UART_TX_PARITY_EN defined:
//    - The PARITY state is built.
//    - Parity bit = ^byte (even parity) by default, or ~^byte when input parity_odd=1.
//    - Adds port: parity_odd  in  1, sampled in the pop cycle.
//    - Frame is 8E1/8O1, or 8E2/8O2 with STOP_BITS=2.
//  UART_TX_PARITY_EN undefined:
//    - No PARITY state and no parity_odd port; DATA goes directly to STOP.
//    - Frame is 8N1/8N2.
// STRUCTURE
//  - Package uart_pkg:
//    - State enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}, 3-bit encoding.
//    - localparam UART_DATA_BITS = 8.
//    - localparam IDLE_LEVEL = 1'b1.
//  - Sub-module uart_baud_tick:
//    - Parameter CLKS_PER_BIT.
//    - Inputs clk, rst, clear. Output tick.
//    - tick pulses for 1 clk at count CLKS_PER_BIT-1; clear restarts the count at 0.
//    - The FSM asserts clear on every state entry.
//  - Top level holds the FSM, the shift register, the bit index, the stop-bit counter and the output registers.
// TESTING (sim with CLKS_PER_BIT=4; model FIFO preloaded, FWFT behaviour)
//  1. Reset with the FIFO empty for 10 clks:
//     tx=1, busy=0, fifo_rd_en never asserted, tx_done=0.
//  2. Single byte 8'hA5, STOP_BITS=1:
//     - exactly one fifo_rd_en pulse;
//     - tx pattern per 4-clk bit: 0,1,0,1,0,0,1,0,1,1;
//     - tx_done 40 clks after the start-bit edge;
//     - busy falls in the same cycle.
//  3. Back-to-back bytes 8'h00 then 8'hFF:
//     - two pops, 41 clks apart;
//     - tx high for exactly 5 clks (stop bit + 1 IDLE cycle) between the frames;
//     - the decoded bytes match.
//  4. Reset at clk 13 of the frame for 8'h3C:
//     - the next cycle has tx=1, busy=0;
//     - with the FIFO still holding 8'h11, the next pop sends 8'h11 and 8'h3C is not resent.
//  5. fifo_data is changed to 8'hFF after the pop while 8'h81 is transmitting:
//     tx still carries 8'h81.
//     With STOP_BITS=2: the stop phase is 8 clks and the frame is 44 clks.
//  6. With UART_TX_PARITY_EN defined, byte 8'h07:
//     - parity_odd=0 gives parity bit 1;
//     - parity_odd=1 gives parity bit 0;
//     - frame is 44 clks at STOP_BITS=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the FIFO-fed UART transmitter.
// Holds the FSM state encoding and frame-level constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic IDLE_LEVEL     = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running bit-period counter, restartable by clear.
// tick is high for one clk at count CLKS_PER_BIT-1.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an FWFT FIFO and sends them as 8N1/8N2 UART.
// Define UART_TX_PARITY_EN to add a parity bit (8E/8O) and the parity_odd port.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
`ifdef UART_TX_PARITY_EN
    ,
    input  logic       parity_odd
`endif
);

    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam uart_tx_state_t DATA_EXIT = PARITY;
`else
    localparam uart_tx_state_t DATA_EXIT = STOP;
`endif

    uart_tx_state_t state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] idx, idx_nxt;
    logic       stop_cnt, stop_nxt;
    logic       tx_nxt, done_nxt;
    logic       tick, baud_clear;

    assign fifo_rd_en = (state == IDLE) && !fifo_empty && !rst;
    assign baud_clear = (state_nxt != state);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

`ifdef UART_TX_PARITY_EN
    logic par;

    always_ff @(posedge clk) begin
        if (rst) begin
            par <= 1'b0;
        end else if (fifo_rd_en) begin
            par <= (^fifo_data) ^ parity_odd;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        idx_nxt   = idx;
        stop_nxt  = stop_cnt;
        done_nxt  = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = START;
                    shreg_nxt = fifo_data;
                end
            end
            START: begin
                if (tick) state_nxt = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt = shreg >> 1;
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'(UART_DATA_BITS - 1)) state_nxt = DATA_EXIT;
                end
            end
            PARITY: begin
                if (tick) state_nxt = STOP;
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        state_nxt = IDLE;
                        stop_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        stop_nxt = stop_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from the next state so it lines up with the state register
    always_comb begin
        tx_nxt = IDLE_LEVEL;
        unique case (state_nxt)
            IDLE, STOP: tx_nxt = IDLE_LEVEL;
            START:      tx_nxt = ~IDLE_LEVEL;
            DATA:       tx_nxt = shreg_nxt[0];
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                tx_nxt = par;
`else
                tx_nxt = IDLE_LEVEL;
`endif
            end
            default:    tx_nxt = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            tx       <= IDLE_LEVEL;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            idx      <= idx_nxt;
            stop_cnt <= stop_nxt;
            tx       <= tx_nxt;
            busy     <= (state_nxt != IDLE);
            tx_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: two DUT lanes (1 and 2 stop bits) fed by FWFT FIFO models;
// a line decoder per lane checks every frame against the bytes pushed.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ndone = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    for (genvar L = 0; L < 2; L++) begin : lane
        localparam int SB = L + 1;
        localparam int FRAME = (9 + PB + SB) * CPB;

        logic       rst = 1'b1;
        logic       fifo_empty, fifo_rd_en, tx, busy, tx_done;
        logic       rd_pend = 1'b0;
        logic [7:0] fifo_data;
        logic [7:0] junk = 8'h00;
        logic [8:0] fq[$];
        logic [8:0] exp_q[$];
        int         pop_cyc[$];
        int pops = 0, bad_pops = 0, pushed = 0, fin = 0, good = 0, dones = 0;
`ifdef UART_TX_PARITY_EN
        logic       parity_odd;
`endif

        fifo_uart_tx #(
            .CLKS_PER_BIT(CPB),
            .STOP_BITS   (SB)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .fifo_data (fifo_data),
            .fifo_empty(fifo_empty),
            .fifo_rd_en(fifo_rd_en),
            .tx        (tx),
            .busy      (busy),
            .tx_done   (tx_done)
`ifdef UART_TX_PARITY_EN
            ,
            .parity_odd(parity_odd)
`endif
        );

        function automatic string nm(input string s);
            return $sformatf("L%0d_%s", L, s);
        endfunction

        task automatic refresh();
            fifo_empty = (fq.size() == 0);
            if (fifo_empty) fifo_data = junk;
            else fifo_data = fq[0][7:0];
`ifdef UART_TX_PARITY_EN
            if (fifo_empty) parity_odd = 1'b0;
            else parity_odd = fq[0][8];
`endif
        endtask

        task automatic tick(input int n = 1);
            repeat (n) begin
                @(posedge clk);
                #2;
            end
        endtask

        task automatic push(input logic [7:0] b, input logic podd);
            fq.push_back({podd, b});
            exp_q.push_back({podd, b});
            pushed++;
            refresh();
        endtask

        task automatic wait_fin(input int n, input string name);
            int t = 0;
            while (fin < n && t < 3000) begin
                tick();
                t++;
            end
            check(nm(name), int'(fin >= n), 1);
        endtask

        // FWFT FIFO model: pop strobe seen mid-cycle, head advances after the edge
        always @(negedge clk) rd_pend <= fifo_rd_en;

        always begin
            @(posedge clk);
            #1;
            if (rd_pend) begin
                pops++;
                pop_cyc.push_back(cyc);
                if (fq.size() == 0) bad_pops++;
                else void'(fq.pop_front());
            end
            refresh();
        end

        always @(negedge clk) if (tx_done) dones <= dones + 1;

        // line decoder: each bit period must hold its expected level for all CPB clks
        always begin : mon
            logic [8:0]  e;
            logic [15:0] lb;
            bit          ok, ab;
            @(negedge clk);
            if (!rst && !tx) begin
                ok = 1'b1;
                ab = 1'b0;
                e  = '0;
                if (exp_q.size() == 0) ok = 1'b0;
                else e = exp_q.pop_front();
                lb    = '1;
                lb[0] = 1'b0;
                for (int k = 0; k < 8; k++) lb[k+1] = e[k];
`ifdef UART_TX_PARITY_EN
                lb[9] = (^e[7:0]) ^ e[8];
`endif
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                    if (tx !== lb[c / CPB] || busy !== 1'b1 || tx_done !== 1'b0)
                        ok = 1'b0;
                end
                if (!ab) begin
                    @(negedge clk);
                    check(nm($sformatf("frame_%02h", e[7:0])), int'(ok), 1);
                    check(nm("frame_end"), int'({tx_done, busy, tx}), 3'b101);
                    good++;
                end
                fin++;
            end
        end

        initial begin : stim
            bit bad;
            int n, sp;
            refresh();
            bad = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (i == 5) push(8'hA5, 1'b0);
                tick();
                if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 ||
                    fifo_rd_en !== 1'b0)
                    bad = 1'b1;
            end
            check(nm("reset_idle"), int'(bad), 0);
            check(nm("reset_no_pop"), pops, 0);
            rst = 1'b0;
            wait_fin(1, "wait_a5");
            check(nm("a5_pops"), pops, 1);
            check(nm("a5_done_pulses"), dones, 1);

            n = pop_cyc.size();
            push(8'h00, 1'b0);
            push(8'hFF, 1'b0);
            wait_fin(3, "wait_b2b");
            sp = (pop_cyc.size() >= n + 2) ? pop_cyc[n+1] - pop_cyc[n] : -1;
            check(nm("b2b_spacing"), sp, FRAME + 1);

            push(8'h3C, 1'b0);
            push(8'h11, 1'b0);
            n = 0;
            while (tx !== 1'b0 && n < 100) begin
                tick();
                n++;
            end
            check(nm("t4_start_seen"), int'(tx === 1'b0), 1);
            tick(12);
            rst = 1'b1;
            tick();
            check(nm("t4_rst_idle"), int'({tx, busy}), 2'b10);
            check(nm("t4_rd_gated"), int'(fifo_rd_en), 0);
            rst = 1'b0;
            wait_fin(5, "wait_11");

            n = pops;
            push(8'h81, 1'b0);
            sp = 0;
            while (pops == n && sp < 100) begin
                tick();
                sp++;
            end
            junk = 8'hFF;
            refresh();
            wait_fin(pushed, "wait_81");
            junk = 8'h00;

`ifdef UART_TX_PARITY_EN
            push(8'h07, 1'b0);
            push(8'h07, 1'b1);
            wait_fin(pushed, "wait_par");
`endif

            for (int i = 0; i < 16; i++) begin
                push(8'($urandom), 1'($urandom_range(0, 1)));
                junk = 8'($urandom);
                tick($urandom_range(0, 60));
            end
            wait_fin(pushed, "wait_rand");

            tick(3);
            check(nm("pops_vs_pushed"), pops, pushed);
            check(nm("bad_pops"), bad_pops, 0);
            check(nm("done_pulses"), dones, good);
            check(nm("exp_left"), exp_q.size(), 0);
            ndone++;
        end
    end

    initial begin
        int t = 0;
        while (ndone < 2 && t < 30000) begin
            @(posedge clk);
            t++;
        end
        check("lanes_done", ndone, 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
